// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU execute stage.
// Contents: default widths, op-code values produced by the ALU control decoder,
// and the execute FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADDU  = 4'd2;
  localparam logic [3:0] ALU_SRAV  = 4'd3;
  localparam logic [3:0] ALU_BEQ   = 4'd4;
  localparam logic [3:0] ALU_SLTIU = 4'd5;
  localparam logic [3:0] ALU_SUBU  = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_ADDI  = 4'd8;
  localparam logic [3:0] ALU_ORI   = 4'd9;
  localparam logic [3:0] ALU_BNE   = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd12;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_LUI   = 4'd14;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier datapath, one partial-product step per cycle.
// Build option: ALU_MUL_EARLY_EXIT_EN ends the multiply as soon as the shifted
// multiplier becomes zero; otherwise exactly DATA_W steps are always taken.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   start_i       load operands (mcand=src1, mplier=src2, acc=0, cnt=0)
//   step_i        perform one step this cycle
//   src1_i/src2_i operands
//   done_o        the step taken this cycle is the last one
//   product_o     accumulator value after this cycle's step (low DATA_W bits)
module alu_shift_add_mul #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_step, mplier_nx;
  logic [CntW-1:0]   cnt_nx;
  logic              last;

  assign acc_step  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mplier_nx = mplier_q >> 1;
  assign cnt_nx    = cnt_q + 1'b1;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Remaining multiplier bits are all zero, so acc can no longer change.
  assign last = (cnt_nx == CntW'(DATA_W)) || (mplier_nx == '0);
`else
  assign last = (cnt_nx == CntW'(DATA_W));
`endif

  assign done_o    = step_i & last;
  assign product_o = acc_step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= src1_i;
      mplier_q <= src2_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_nx;
      acc_q    <= acc_step;
      cnt_q    <= cnt_nx;
    end
  end

endmodule

// File: rtl/alu_mc_exec.sv
// Multi-cycle execute stage fed by the ALU control decoder.
// Single-cycle ops finish at the accept edge; mul runs iteratively in
// alu_shift_add_mul while ready_o is low (stalls fetch).
// Build option: ALU_MUL_EARLY_EXIT_EN (see alu_shift_add_mul).
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   valid_i, ready_o  op handshake; accept = valid_i & ready_o
//   ctrl_i            op code
//   src1_i, src2_i    operands; shamt_i shift amount for sra
//   result_o, zero_o  registered result and branch flag
//   valid_o           one-cycle pulse when result_o/zero_o update
//   busy_o            multiply in progress
module alu_mc_exec
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CTRL_W = ALU_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              busy_o
);

  alu_state_e        state_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, valid_q;
  logic [DATA_W-1:0] res_c;
  logic              zero_c;
  logic              accept, mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q == MUL);
  assign accept    = valid_i & ready_o;
  assign mul_start = accept & (ctrl_i == ALU_MUL);

  alu_shift_add_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .step_i    (busy_o),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    res_c = '0;
    unique case (ctrl_i)
      ALU_AND:             res_c = src1_i & src2_i;
      ALU_OR, ALU_ORI:     res_c = src1_i | src2_i;
      ALU_ADDU, ALU_ADDI:  res_c = src1_i + src2_i;
      ALU_SUBU, ALU_BEQ,
      ALU_BNE:             res_c = src1_i - src2_i;
      ALU_SLT:   res_c = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_SLTIU: res_c = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
      ALU_LUI:   res_c = src2_i << 16;
      ALU_SRA:   res_c = DATA_W'($signed(src2_i) >>> shamt_i);
      ALU_SRAV:  res_c = DATA_W'($signed(src2_i) >>> src1_i[4:0]);
      default:   res_c = '0;
    endcase
    // bne inverts so the branch unit can always branch on zero_o.
    zero_c = (ctrl_i == ALU_BNE) ? (res_c != '0) : (res_c == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q <= MUL;
          end else if (accept) begin
            result_q <= res_c;
            zero_q   <= zero_c;
            valid_q  <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            result_q <= mul_product;
            zero_q   <= (mul_product == '0);
            valid_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_alu_mc_exec.sv
module tb_alu_mc_exec;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  ctrl_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic [31:0] result_o;
  logic        zero_o, valid_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  alu_mc_exec dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the op-code table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic z);
    longint unsigned p;
    case (op)
      4'd0:        r = a & b;
      4'd1, 4'd9:  r = a | b;
      4'd2, 4'd8:  r = a + b;
      4'd6, 4'd4, 4'd10: r = a - b;
      4'd7:        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:        r = (a < b) ? 32'd1 : 32'd0;
      4'd14:       r = {b[15:0], 16'h0000};
      4'd13:       r = $signed(b) >>> sh;
      4'd3:        r = $signed(b) >>> a[4:0];
      4'd12: begin
        p = longint'(a) * longint'(b);
        r = p[31:0];
      end
      default:     r = 32'd0;
    endcase
    z = (op == 4'd10) ? (r != 0) : (r == 0);
  endfunction

  function automatic int mul_steps(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    // Steps until all remaining multiplier bits are zero: msb index + 1, minimum 1.
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic        ez;
    int          cyc;
    model(op, a, b, sh, er, ez);
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk_i); #1; cyc++;
    end
    chk({tag, "_ready_in"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; ctrl_i = op; src1_i = a; src2_i = b; shamt_i = sh;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    cyc = 0;
    while (!valid_o && cyc < 100) begin
      chk({tag, "_busy"}, {30'd0, busy_o, ready_o}, 32'b10);
      if (poke) begin
        // Offered while stalled; must be dropped.
        valid_i = 1'b1; ctrl_i = 4'd2; src1_i = $urandom; src2_i = $urandom;
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), (op == 4'd12) ? 32'(mul_steps(b)) : 32'd0);
    chk({tag, "_res"}, result_o, er);
    chk({tag, "_zero"}, 32'(zero_o), 32'(ez));
    chk({tag, "_rdy_out"}, 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    chk({tag, "_pulse"}, 32'(valid_o), 32'd0);
    chk({tag, "_hold"}, result_o, er);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          nvalid;

    // Reset state
    #12;
    chk("rst_res", result_o, 32'd0);
    chk("rst_flags", {28'd0, zero_o, valid_o, busy_o, ready_o}, 32'b0001);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Back-to-back single-cycle ops
    valid_i = 1'b1; ctrl_i = 4'd2; src1_i = 32'hFFFF_FFFF; src2_i = 32'd1;
    @(posedge clk_i); #1;
    chk("addu_res", result_o, 32'd0);
    chk("addu_zv", {30'd0, zero_o, valid_o}, 32'b11);
    ctrl_i = 4'd6; src1_i = 32'd3; src2_i = 32'd5;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("subu_res", result_o, 32'hFFFF_FFFE);
    chk("subu_zv", {30'd0, zero_o, valid_o}, 32'b01);
    @(posedge clk_i); #1;
    chk("b2b_end", 32'(valid_o), 32'd0);

    // Directed ops
    run_op("slt",   4'd7,  32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sltiu", 4'd5,  32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sra",   4'd13, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
    run_op("lui",   4'd14, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
    run_op("beq",   4'd4,  32'd7, 32'd7, 5'd0, 1'b0);
    run_op("bne_eq", 4'd10, 32'd7, 32'd7, 5'd0, 1'b0);
    run_op("bne_ne", 4'd10, 32'd7, 32'd8, 5'd0, 1'b0);
    run_op("undef", 4'd11, 32'd9, 32'd4, 5'd0, 1'b0);
    run_op("mul",   4'd12, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1);
    run_op("mul_ff", 4'd12, 32'd123, 32'h0000_00FF, 5'd0, 1'b1);
    run_op("mul_0", 4'd12, 32'd5, 32'd0, 5'd0, 1'b0);
    run_op("mul_1", 4'd12, 32'd77, 32'd1, 5'd0, 1'b0);

    // Reset in the middle of a multiply
    valid_i = 1'b1; ctrl_i = 4'd12; src1_i = 32'd9; src2_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_res", result_o, 32'd0);
    chk("mrst_flags", {28'd0, zero_o, valid_o, busy_o, ready_o}, 32'b0001);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) nvalid++;
    end
    chk("mrst_novalid", 32'(nvalid), 32'd0);
    chk("mrst_ready", 32'(ready_o), 32'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = b & 32'h0000_00FF;
        1: a = a & 32'h0000_000F;
        default: ;
      endcase
      run_op("rand", op, a, b, 5'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
